// File: rtl/b_shift_pkg.sv
// Shared constants for the ARM7 operand2 barrel shifter: shift-type encodings
// and the bit positions of the instruction fields the shifter decodes.
package b_shift_pkg;

  localparam int DW = 32;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Position of the I bit in the full instruction word (carried as instr_bit_25).
  localparam int I_BIT_POS = 25;

  // Fields inside imm_value (instruction bits [11:0]).
  localparam int ROT_HI        = 11;
  localparam int ROT_LO        = 8;
  localparam int IMM8_HI       = 7;
  localparam int IMM8_LO       = 0;
  localparam int SHAMT_HI      = 11;
  localparam int SHAMT_LO      = 7;
  localparam int SHTYPE_HI     = 6;
  localparam int SHTYPE_LO     = 5;
  localparam int REG_SHIFT_POS = 4;

endpackage

// File: rtl/bshift_core.sv
// Combinational ARM shifter: applies LSL/LSR/ASR/ROR with the ARM special
// cases for a zero immediate amount and for register amounts of 32 and above.
module bshift_core
  import b_shift_pkg::*;
(
  input  logic [1:0]    sh_type,
  input  logic [7:0]    amount,
  input  logic          reg_shift,
  input  logic [DW-1:0] data,
  input  logic          cin,
  output logic [DW-1:0] result,
  output logic          carry
);

  logic [4:0]    amt5;
  logic [4:0]    amt_m1;
  logic [4:0]    amt_neg;
  logic          big;
  logic          sign;
  logic [DW-1:0] lsl_r;
  logic [DW-1:0] lsr_r;
  logic [DW-1:0] asr_r;
  logic [DW-1:0] ror_r;

  assign amt5    = amount[4:0];
  assign amt_m1  = amt5 - 5'd1;
  // 32 - amt5 modulo 32: the last bit shifted out by LSL and the ROR left part.
  assign amt_neg = 5'd0 - amt5;
  assign big     = reg_shift & (|amount[7:5]);
  assign sign    = data[DW-1];

  assign lsl_r = data << amt5;
  assign lsr_r = data >> amt5;
  assign asr_r = $signed(data) >>> amt5;
  assign ror_r = (data >> amt5) | (data << amt_neg);

  always_comb begin
    result = data;
    carry  = cin;
    if (!reg_shift && amt5 == 5'd0) begin
      // Immediate amount 0 re-encodes LSR/ASR #32 and RRX.
      case (sh_type)
        SH_LSL: begin result = data;            carry = cin;     end
        SH_LSR: begin result = '0;              carry = sign;    end
        SH_ASR: begin result = {DW{sign}};      carry = sign;    end
        default: begin result = {cin, data[DW-1:1]}; carry = data[0]; end
      endcase
    end else if (reg_shift && amount == 8'd0) begin
      result = data;
      carry  = cin;
    end else begin
      case (sh_type)
        SH_LSL: begin
          if (big) begin
            result = '0;
            carry  = (amount == 8'd32) ? data[0] : 1'b0;
          end else begin
            result = lsl_r;
            carry  = data[amt_neg];
          end
        end
        SH_LSR: begin
          if (big) begin
            result = '0;
            carry  = (amount == 8'd32) ? sign : 1'b0;
          end else begin
            result = lsr_r;
            carry  = data[amt_m1];
          end
        end
        SH_ASR: begin
          if (big) begin
            result = {DW{sign}};
            carry  = sign;
          end else begin
            result = asr_r;
            carry  = data[amt_m1];
          end
        end
        default: begin
          if (amt5 == 5'd0) begin
            result = data;
            carry  = sign;
          end else begin
            result = ror_r;
            carry  = data[amt_m1];
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/b_shift.sv
// Registered operand2 generator: selects immediate-rotate or register-shift
// operands, runs them through bshift_core and registers result and carry.
module b_shift
  import b_shift_pkg::*;
#(
  parameter int n = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_bit_25,
  input  logic [11:0]   imm_value,
  input  logic [n-1:0]  Rm,
  input  logic [n-1:0]  Rs,
  input  logic          cin,
  output logic [n-1:0]  operand2,
  output logic          c_to_alu
);

  logic [1:0]   core_type;
  logic [7:0]   core_amt;
  logic         core_reg;
  logic [n-1:0] core_data;
  logic [n-1:0] operand2_d;
  logic [n-1:0] operand2_q;
  logic         c_d;
  logic         c_q;
  logic         unused_rs_hi;

  assign unused_rs_hi = ^Rs[n-1:8];

  // The rotated immediate is a register-style ROR by 2*rot: amount 0 keeps
  // cin, and the ROR carry equals result[31] for any non-zero rotation.
  always_comb begin
    core_type = imm_value[SHTYPE_HI:SHTYPE_LO];
    core_amt  = {3'b000, imm_value[SHAMT_HI:SHAMT_LO]};
    core_reg  = imm_value[REG_SHIFT_POS];
    core_data = Rm;
    if (instr_bit_25) begin
      core_type = SH_ROR;
      core_amt  = {3'b000, imm_value[ROT_HI:ROT_LO], 1'b0};
      core_reg  = 1'b1;
      core_data = {{(n-8){1'b0}}, imm_value[IMM8_HI:IMM8_LO]};
    end else if (imm_value[REG_SHIFT_POS]) begin
      core_amt  = Rs[7:0];
    end
  end

  bshift_core u_core (
    .sh_type   (core_type),
    .amount    (core_amt),
    .reg_shift (core_reg),
    .data      (core_data),
    .cin       (cin),
    .result    (operand2_d),
    .carry     (c_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      operand2_q <= '0;
      c_q        <= 1'b0;
    end else begin
      operand2_q <= operand2_d;
      c_q        <= c_d;
    end
  end

  assign operand2 = operand2_q;
  assign c_to_alu = c_q;

endmodule

// File: tb/tb_b_shift.sv
// Bench for b_shift: hand-computed vector table, reset sequences and random
// vectors checked against a bit-serial shifter model via an expected queue.
module tb_b_shift;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_bit_25 = 1'b0;
  logic [11:0] imm_value = '0;
  logic [31:0] Rm = '0;
  logic [31:0] Rs = '0;
  logic        cin = 1'b0;
  logic [31:0] operand2;
  logic        c_to_alu;

  int n_checks = 0;
  int n_pass   = 0;

  logic [32:0] exp_q[$];

  typedef struct {
    logic        i;
    logic [11:0] imm;
    logic [31:0] rm;
    logic [31:0] rs;
    logic        c_in;
    logic [31:0] op;
    logic        c;
  } vec_t;

  vec_t vecs[18];

  b_shift #(.n(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_bit_25 (instr_bit_25),
    .imm_value    (imm_value),
    .Rm           (Rm),
    .Rs           (Rs),
    .cin          (cin),
    .operand2     (operand2),
    .c_to_alu     (c_to_alu)
  );

  always #5 clk = ~clk;

  // Reference: shifts one bit at a time, tracking the last bit shifted out.
  function automatic logic [32:0] ref_shift(input logic i, input logic [11:0] imm,
                                            input logic [31:0] rm, input logic [31:0] rs,
                                            input logic c_in);
    logic [31:0] r;
    logic        c;
    logic [1:0]  t;
    int          s;
    if (i) begin
      r = {24'b0, imm[7:0]};
      c = c_in;
      for (int k = 0; k < 2 * int'(imm[11:8]); k++) begin
        r = {r[0], r[31:1]};
        c = r[31];
      end
      return {c, r};
    end
    t = imm[6:5];
    r = rm;
    c = c_in;
    if (imm[4]) s = int'(rs[7:0]);
    else begin
      s = int'(imm[11:7]);
      if (s == 0) begin
        if (t == 2'b01 || t == 2'b10) s = 32;
        else if (t == 2'b11) return {rm[0], c_in, rm[31:1]};
      end
    end
    for (int k = 0; k < s; k++) begin
      case (t)
        2'b00:   begin c = r[31]; r = {r[30:0], 1'b0}; end
        2'b01:   begin c = r[0];  r = {1'b0, r[31:1]}; end
        2'b10:   begin c = r[0];  r = {r[31], r[31:1]}; end
        default: begin c = r[0];  r = {r[0], r[31:1]}; end
      endcase
    end
    return {c, r};
  endfunction

  task automatic drive(input logic i, input logic [11:0] imm, input logic [31:0] rm,
                       input logic [31:0] rs, input logic c_in);
    instr_bit_25 = i;
    imm_value    = imm;
    Rm           = rm;
    Rs           = rs;
    cin          = c_in;
  endtask

  task automatic check_pair(input int id, input logic [31:0] e_op, input logic e_c);
    n_checks++;
    if (operand2 === e_op) n_pass++;
    else $display("FAIL chk%0d operand2: got %h expected %h", id, operand2, e_op);
    n_checks++;
    if (c_to_alu === e_c) n_pass++;
    else $display("FAIL chk%0d c_to_alu: got %b expected %b", id, c_to_alu, e_c);
  endtask

  task automatic check_out(input int id);
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL chk%0d scoreboard: got empty queue expected entry", id);
    end else begin
      e = exp_q.pop_front();
      check_pair(id, e[31:0], e[32]);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 12'h060, 32'h60000001, 32'd100, 1'b1, 32'h00000060, 1'b1};
    vecs[1]  = '{1'b1, 12'h4FF, 32'h0,        32'd0,   1'b0, 32'hFF000000, 1'b1};
    vecs[2]  = '{1'b0, 12'h060, 32'h60000001, 32'd0,   1'b1, 32'hB0000000, 1'b1};
    vecs[3]  = '{1'b0, 12'h010, 32'hF0000001, 32'd100, 1'b1, 32'h00000000, 1'b0};
    vecs[4]  = '{1'b0, 12'h010, 32'hF0000001, 32'd4,   1'b0, 32'h00000010, 1'b1};
    vecs[5]  = '{1'b0, 12'h020, 32'h80000000, 32'd0,   1'b0, 32'h00000000, 1'b1};
    vecs[6]  = '{1'b0, 12'h240, 32'h80000000, 32'd0,   1'b1, 32'hF8000000, 1'b0};
    vecs[7]  = '{1'b0, 12'h010, 32'h00000001, 32'd32,  1'b0, 32'h00000000, 1'b1};
    vecs[8]  = '{1'b0, 12'h030, 32'h80000000, 32'd32,  1'b0, 32'h00000000, 1'b1};
    vecs[9]  = '{1'b0, 12'h030, 32'hFFFFFFFF, 32'd33,  1'b1, 32'h00000000, 1'b0};
    vecs[10] = '{1'b0, 12'h050, 32'h80000000, 32'd200, 1'b0, 32'hFFFFFFFF, 1'b1};
    vecs[11] = '{1'b0, 12'h070, 32'h80000001, 32'd64,  1'b0, 32'h80000001, 1'b1};
    vecs[12] = '{1'b0, 12'h070, 32'h12345678, 32'd0,   1'b1, 32'h12345678, 1'b1};
    vecs[13] = '{1'b0, 12'h000, 32'hDEADBEEF, 32'd0,   1'b0, 32'hDEADBEEF, 1'b0};
    vecs[14] = '{1'b0, 12'h080, 32'h80000001, 32'd0,   1'b0, 32'h00000002, 1'b1};
    vecs[15] = '{1'b0, 12'h040, 32'h7FFFFFFF, 32'd0,   1'b1, 32'h00000000, 1'b0};
    vecs[16] = '{1'b0, 12'h460, 32'h000000AB, 32'd0,   1'b0, 32'hAB000000, 1'b1};
    vecs[17] = '{1'b1, 12'hF01, 32'h0,        32'd0,   1'b1, 32'h00000004, 1'b0};

    // Reset state with non-zero inputs present.
    drive(1'b1, 12'h4FF, 32'hFFFFFFFF, 32'd4, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_pair(0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors, one per cycle.
    for (int v = 0; v < 18; v++) begin
      @(negedge clk);
      drive(vecs[v].i, vecs[v].imm, vecs[v].rm, vecs[v].rs, vecs[v].c_in);
      exp_q.push_back({vecs[v].c, vecs[v].op});
      @(posedge clk);
      #1;
      check_out(100 + v);
    end

    // Mid-stream asynchronous reset.
    @(negedge clk);
    drive(1'b1, 12'h4FF, 32'h0, 32'd0, 1'b0);
    exp_q.push_back({1'b1, 32'hFF000000});
    @(posedge clk);
    #1;
    check_out(200);
    #2;
    rst = 1'b1;
    #1;
    check_pair(201, 32'h0, 1'b0);
    exp_q.delete();
    @(posedge clk);
    #1;
    check_pair(202, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_pair(203, 32'h0, 1'b0);
    exp_q.push_back({1'b1, 32'hFF000000});
    @(posedge clk);
    #1;
    check_out(204);

    // Random vectors against the reference model.
    for (int r = 0; r < 60; r++) begin
      logic        ri;
      logic [11:0] rimm;
      logic [31:0] rrm;
      logic [31:0] rrs;
      logic        rc;
      ri   = ($urandom_range(0, 3) == 0);
      rimm = 12'($urandom_range(0, 4095));
      rrm  = $urandom;
      rrs  = $urandom;
      if ($urandom_range(0, 2) != 0) rrs[7:0] = 8'($urandom_range(0, 40));
      rc   = 1'($urandom_range(0, 1));
      @(negedge clk);
      drive(ri, rimm, rrm, rrs, rc);
      exp_q.push_back(ref_shift(ri, rimm, rrm, rrs, rc));
      @(posedge clk);
      #1;
      check_out(300 + r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
